// File: rtl/timer_dev.sv
// timer_dev: countdown timer peripheral on the CPU device bus (responder side).
//
// Three registers are mapped by word address, addr[3:2]:
//    0  CTRL   = {28'b0, IM, MODE[1:0], EN}   (read/write, byte 0 only)
//    1  PRESET = reload value                 (read/write, byte-enabled)
//    2  COUNT  = current count                (read-only)
//    3  unmapped, reads 0, writes ignored
// Once enabled, the FSM loads COUNT from PRESET and counts down to 0. It then
// raises the expiry flag. In periodic mode (MODE=01) it reloads on its own.
// In any other mode it clears EN and parks in IDLE.
//
// Ports:
//    clk   in   1   system clock, rising edge
//    rst   in   1   synchronous active-high reset
//    addr  in  32   bus byte address (only [3:2] decoded)
//    we    in   1   bus write strobe (already device-selected)
//    be    in   4   write byte enables, be[i] gates din[8i+7:8i]
//    din   in  32   bus write data
//    dout  out 32   read data, combinational from addr[3:2]
//    irq   out  1   interrupt request, IM & flag
module timer_dev #(
   parameter logic [3:0]  CTRL_RST   = 4'h0,
   parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        flag_q, flag_d;

   logic        wr_ctrl_s;
   logic        wr_preset_s;
   logic        ctrl_byte_wr_s;
   logic [3:0]  ctrl_eff_s;
   logic        en_s;
   logic        periodic_s;
   logic        unused_addr_s;

   // Only addr[3:2] takes part in decoding.
   assign unused_addr_s = ^{addr[31:4], addr[1:0]};

   assign wr_ctrl_s      = we && (addr[3:2] == 2'd0);
   assign wr_preset_s    = we && (addr[3:2] == 2'd1);
   assign ctrl_byte_wr_s = wr_ctrl_s && be[0];

   // The FSM decides on CTRL as it will be after this edge's bus write.
   // A write of EN therefore takes effect on the same edge. This is what
   // makes the write-EN edge move IDLE straight to LOAD.
   assign ctrl_eff_s = ctrl_byte_wr_s ? din[3:0] : ctrl_q;
   assign en_s       = ctrl_eff_s[0];
   assign periodic_s = (ctrl_eff_s[2:1] == 2'b01);

   assign irq = ctrl_q[3] & flag_q;

   // Read mux, no side effects.
   always_comb begin
      dout = 32'h0000_0000;
      case (addr[3:2])
         2'd0:    dout = {28'h000_0000, ctrl_q};
         2'd1:    dout = preset_q;
         2'd2:    dout = count_q;
         default: dout = 32'h0000_0000;
      endcase
   end

   // Next-state logic: bus writes, FSM sequencing, expiry flag.
   always_comb begin
      ctrl_d   = ctrl_eff_s;
      preset_d = preset_q;
      count_d  = count_q;
      state_d  = state_q;

      for (int i = 0; i < 4; i++) begin
         if (wr_preset_s && be[i]) begin
            preset_d[8*i +: 8] = din[8*i +: 8];
         end else begin
            preset_d[8*i +: 8] = preset_q[8*i +: 8];
         end
      end

      // Any bus write to CTRL or PRESET acknowledges the flag. A flag set by
      // the FSM further down overrides this on the same edge.
      if (wr_ctrl_s || wr_preset_s) begin
         flag_d = 1'b0;
      end else begin
         flag_d = flag_q;
      end

      case (state_q)
         S_IDLE: begin
            if (en_s) begin
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            // A PRESET write on this same edge is not seen until the next load.
            if (en_s) begin
               count_d = preset_q;
               state_d = S_CNT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CNT: begin
            if (!en_s) begin
               state_d = S_IDLE;
            end else if (count_q != 32'd0) begin
               count_d = count_q - 32'd1;
            end else begin
               state_d = S_INT;
               flag_d  = 1'b1;
            end
         end
         S_INT: begin
            if (periodic_s) begin
               state_d = S_LOAD;
               flag_d  = 1'b0;
            end else begin
               state_d = S_IDLE;
               // A CTRL write on this edge wins over the automatic EN clear.
               if (ctrl_byte_wr_s) begin
                  ctrl_d = din[3:0];
               end else begin
                  ctrl_d = {ctrl_q[3:1], 1'b0};
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ctrl_q   <= CTRL_RST;
         preset_q <= PRESET_RST;
         count_q  <= 32'd0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
      end
   end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev.
// Each cycle the bench drives the bus at the falling edge. It checks dout/irq
// 3 ns later, which is before the next rising edge. A check therefore shows
// the state left by the previous rising edges. The write driven in that cycle
// takes effect on the rising edge that follows the check.
module tb_timer_dev;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   int n_tests;
   int n_fail;

   typedef struct {
      logic        rst;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] din;
      logic        chk;
      logic [31:0] exp_dout;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   timer_dev dut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr),
      .we   (we),
      .be   (be),
      .din  (din),
      .dout (dout),
      .irq  (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d, input logic c,
                      input logic [31:0] ed, input logic ei);
      vec_t v;
      v.rst = r; v.we = w; v.addr = a; v.be = b; v.din = d;
      v.chk = c; v.exp_dout = ed; v.exp_irq = ei;
      vecs.push_back(v);
   endtask

   task automatic cyc(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
      @(negedge clk);
      rst  = r;
      we   = w;
      addr = a;
      be   = b;
      din  = d;
      #3;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_both(input string nm, input logic [31:0] ed, input logic ei);
      check({nm, ".dout"}, dout, ed);
      check({nm, ".irq"}, {31'd0, irq}, {31'd0, ei});
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst  = 1'b1;
      we   = 1'b0;
      addr = 32'h0;
      be   = 4'h0;
      din  = 32'h0;

      // Reset, then read every address.
      add(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      add(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'h4, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'hC, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      // Byte enables, COUNT write ignored, unmapped address.
      add(1'b0, 1'b1, 32'h4, 4'b0001, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'h4, 4'h0, 32'h0, 1'b1, 32'h0000_00FF, 1'b0);
      add(1'b0, 1'b1, 32'h8, 4'hF, 32'h1234, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b1, 32'hC, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'hC, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b1, 32'h4, 4'b0110, 32'hAABB_CCDD, 1'b1, 32'h0000_00FF, 1'b0);
      add(1'b0, 1'b0, 32'h4, 4'h0, 32'h0, 1'b1, 32'h00BB_CCFF, 1'b0);
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      // One-shot with IM: PRESET=5, CTRL=0x9 (write edge E0).
      add(1'b0, 1'b1, 32'h4, 4'hF, 32'h5, 1'b1, 32'h00BB_CCFF, 1'b0);
      add(1'b0, 1'b1, 32'h0, 4'hF, 32'h9, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);   // after E0: LOAD
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h5, 1'b0);   // after E1
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h4, 1'b0);
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h3, 1'b0);
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h2, 1'b0);
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h1, 1'b0);
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);   // after E6
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1);   // after E7: irq
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8, 1'b1);   // after E8: EN cleared
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8, 1'b1);
      add(1'b0, 1'b1, 32'h0, 4'hF, 32'h8, 1'b1, 32'h8, 1'b1);   // ack write
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8, 1'b0);
      // IM=0: PRESET=2, CTRL=0x1.
      add(1'b0, 1'b1, 32'h4, 4'hF, 32'h2, 1'b1, 32'h5, 1'b0);
      add(1'b0, 1'b1, 32'h0, 4'hF, 32'h1, 1'b1, 32'h8, 1'b0);
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h1, 1'b0);   // after E0
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h1, 1'b0);
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h1, 1'b0);
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h1, 1'b0);
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h1, 1'b0);   // after E4: INT
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);   // after E5: EN cleared
      add(1'b0, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b1, 32'h0, 4'hF, 32'h8, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].din);
         if (vecs[i].chk) begin
            chk_both($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_irq);
         end
      end

      // Periodic: PRESET=3, CTRL=0xB -> 1-cycle pulses 6 cycles apart.
      cyc(1'b0, 1'b1, 32'h4, 4'hF, 32'h3);
      cyc(1'b0, 1'b1, 32'h0, 4'hF, 32'hB);
      for (int j = 0; j < 24; j++) begin
         cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
         chk_both($sformatf("per3_e%0d", j), 32'hB,
                  (j >= 5) && (((j - 5) % 6) == 0));
      end
      cyc(1'b0, 1'b1, 32'h0, 4'hF, 32'h0);

      // PRESET=0 periodic: irq after E2, period 3.
      cyc(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      cyc(1'b0, 1'b1, 32'h0, 4'hF, 32'hB);
      for (int j = 0; j < 12; j++) begin
         cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
         chk_both($sformatf("per0_e%0d", j), 32'hB, (j % 3) == 2);
      end

      // A CTRL write in INT wins over the automatic EN clear.
      cyc(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      cyc(1'b0, 1'b1, 32'h0, 4'hF, 32'h9);                      // E0
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk_both("col_e0", 32'h9, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk_both("col_e1", 32'h9, 1'b0);
      cyc(1'b0, 1'b1, 32'h0, 4'hF, 32'h9);                      // write at E3
      chk_both("col_e2", 32'h9, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk_both("col_e3", 32'h9, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk_both("col_e4", 32'h9, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk_both("col_e5", 32'h9, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk_both("col_e6", 32'h9, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk_both("col_e7", 32'h8, 1'b1);

      // Flag set and clear-by-write on the same edge: flag stays set.
      cyc(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      cyc(1'b0, 1'b1, 32'h0, 4'hF, 32'h9);                      // E0
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      cyc(1'b0, 1'b1, 32'h4, 4'hF, 32'h0);                      // write at E2
      chk_both("setclr_pre", 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk_both("setclr_post", 32'h9, 1'b1);

      // Disable mid-count: PRESET=100, CTRL=0x9, CTRL=0x8 at E10 -> frozen at 92.
      cyc(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      cyc(1'b0, 1'b1, 32'h4, 4'hF, 32'd100);
      cyc(1'b0, 1'b1, 32'h0, 4'hF, 32'h9);                      // E0
      for (int j = 0; j < 9; j++) begin
         cyc(1'b0, 1'b0, 32'h8, 4'h0, 32'h0);
         chk_both($sformatf("cnt100_e%0d", j), (j == 0) ? 32'd0 : 32'(101 - j), 1'b0);
      end
      cyc(1'b0, 1'b1, 32'h0, 4'hF, 32'h8);                      // E10
      chk_both("cnt100_dis", 32'h9, 1'b0);
      for (int j = 0; j < 20; j++) begin
         cyc(1'b0, 1'b0, 32'h8, 4'h0, 32'h0);
         if (j == 0 || j == 19) begin
            chk_both($sformatf("frozen_%0d", j), 32'd92, 1'b0);
         end else begin
            check($sformatf("frozen_irq_%0d", j), {31'd0, irq}, 32'd0);
         end
      end

      // Reset in the middle of a count.
      cyc(1'b0, 1'b1, 32'h0, 4'hF, 32'h9);
      for (int j = 0; j < 5; j++) begin
         cyc(1'b0, 1'b0, 32'h8, 4'h0, 32'h0);
      end
      chk_both("midrst_pre", 32'd97, 1'b0);
      cyc(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
      cyc(1'b0, 1'b0, 32'h8, 4'h0, 32'h0);
      chk_both("midrst_cnt", 32'd0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk_both("midrst_ctrl", 32'd0, 1'b0);
      cyc(1'b0, 1'b0, 32'h4, 4'h0, 32'h0);
      chk_both("midrst_preset", 32'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
